// File: rtl/ripple_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ripple_cap_pkg
// Purpose  : Shared definitions for the ripple counter capture stage:
//            default widths, agreement counter width and the snapshot FSM
//            state encoding.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package ripple_cap_pkg;

    localparam int c_CW_DEFAULT     = 4;
    localparam int c_EXT_W_DEFAULT  = 12;
    localparam int c_STABLE_DEFAULT = 2;

    // Agreement counter width; holds STABLE-1 for the whole legal range 1..15.
    localparam int c_AGR_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } snap_state_t;

endpackage : ripple_cap_pkg
`default_nettype wire

// File: rtl/ripple_count_capture_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter
// Purpose  : Three-stage synchronizer for the asynchronous ripple counter
//            value plus an agreement counter that qualifies a value once the
//            last two synchronized samples have agreed long enough.
// Ports    : clk      - sampling clock, rising edge
//            rst_i    - asynchronous active-high reset
//            cnt_i    - raw ripple counter value (asynchronous)
//            accept_o - current synchronized value is qualified (stable)
//            value_o  - synchronized value (s2) being qualified
// Revision : 1.0 - initial release
// ============================================================================
module sync_filter
    import ripple_cap_pkg::*;
#(
    parameter int CW     = c_CW_DEFAULT,
    parameter int STABLE = c_STABLE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [CW-1:0] cnt_i,
    output logic          accept_o,
    output logic [CW-1:0] value_o
);

    localparam logic [c_AGR_W-1:0] c_AGR_MAX = c_AGR_W'(STABLE - 1);

    logic [CW-1:0]      s1_q, s2_q, s3_q;
    logic [2:0]         fill_q;
    logic [c_AGR_W-1:0] agr_q, agr_d;
    logic               w_agree;
    logic               w_sat;

    // The reset contents of s2/s3 are not real samples of the counter. A
    // fill marker travels alongside the data so that two reset zeros are
    // never taken as an agreeing pair (which would prime the capture with a
    // bogus 0 right after reset).
    assign w_agree = fill_q[2] && (s2_q == s3_q);
    assign w_sat   = (agr_q == c_AGR_MAX);

    always_comb begin
        agr_d = agr_q;
        if (!w_agree) begin
            agr_d = '0;
        end else if (!w_sat) begin
            agr_d = agr_q + c_AGR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            fill_q <= '0;
            agr_q  <= '0;
        end else begin
            s1_q   <= cnt_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fill_q <= {fill_q[1:0], 1'b1};
            agr_q  <= agr_d;
        end
    end

    assign accept_o = w_agree && w_sat;
    assign value_o  = s2_q;

endmodule : sync_filter
`default_nettype wire

// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_capture
// Purpose  : Capture stage for a 4-bit asynchronous ripple counter. Filters
//            the synchronized count, extends it with a wrap-driven upper
//            field, flags illegal jumps and serves snapshots over valid/ready.
// Ports    : clk        - sampling clock, rising edge
//            rstn       - asynchronous reset, ACTIVE-HIGH despite the name
//            cnt_in     - ripple counter value (asynchronous)
//            snap_req   - single-cycle snapshot request
//            out_ready  - consumer accepts out_data
//            out_valid  - snapshot held on out_data
//            out_data   - snapshot {ext, stb}
//            wrap_pulse - one-cycle pulse after a 2^CW-1 -> 0 accept
//            snap_drop  - one-cycle pulse when a request is lost
//            err_jump   - sticky illegal-jump flag
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int CW     = c_CW_DEFAULT,
    parameter int EXT_W  = c_EXT_W_DEFAULT,
    parameter int STABLE = c_STABLE_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CW-1:0]       cnt_in,
    input  logic                snap_req,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [EXT_W+CW-1:0] out_data,
    output logic                wrap_pulse,
    output logic                snap_drop,
    output logic                err_jump
);

    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};

    logic          w_flt_accept;
    logic [CW-1:0] w_flt_value;

    sync_filter #(
        .CW     (CW),
        .STABLE (STABLE)
    ) u_sync_filter (
        .clk      (clk),
        .rst_i    (rstn),
        .cnt_i    (cnt_in),
        .accept_o (w_flt_accept),
        .value_o  (w_flt_value)
    );

    // ------------------------------------------------------------------
    // Accepted value, extension, wrap and jump tracking
    // ------------------------------------------------------------------
    logic [CW-1:0]    stb_q, stb_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic             primed_q, primed_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             w_take;
    logic [CW-1:0]    w_stb_inc;

    // A qualified value is only taken when it differs from the held one,
    // except for the very first (priming) accept after reset.
    assign w_take    = w_flt_accept && (!primed_q || (w_flt_value != stb_q));
    assign w_stb_inc = stb_q + c_CNT_ONE;

    always_comb begin
        stb_d    = stb_q;
        ext_d    = ext_q;
        primed_d = primed_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        if (w_take) begin
            stb_d    = w_flt_value;
            primed_d = 1'b1;
            if (primed_q) begin
                if ((w_flt_value == '0) && (stb_q == c_CNT_MAX)) begin
                    ext_d  = ext_q + EXT_W'(1);
                    wrap_d = 1'b1;
                end
                if (w_flt_value != w_stb_inc) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            stb_q    <= '0;
            ext_q    <= '0;
            primed_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stb_q    <= stb_d;
            ext_q    <= ext_d;
            primed_q <= primed_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot FSM. The snapshot uses the registered {ext, stb}, so a
    // request coinciding with an accept sees the pre-update value.
    // ------------------------------------------------------------------
    snap_state_t          state_q, state_d;
    logic                 valid_q, valid_d;
    logic [EXT_W+CW-1:0]  data_q, data_d;
    logic                 drop_q, drop_d;
    logic [EXT_W+CW-1:0]  w_snap;

    assign w_snap = {ext_q, stb_q};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    data_d  = w_snap;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (valid_q && out_ready) begin
                    if (snap_req) begin
                        data_d = w_snap;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (snap_req) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign wrap_pulse = wrap_q;
    assign snap_drop  = drop_q;
    assign err_jump   = err_q;

endmodule : ripple_count_capture
`default_nettype wire
